// File: rtl/mux_packer_pkg.sv
// Shared definitions for the demux/mux_packer pair: select encoding, packer
// state type and default bus widths.
package mux_packer_pkg;

   localparam logic [1:0] SEL_CAESAR  = 2'd0;
   localparam logic [1:0] SEL_SCYTALE = 2'd1;
   localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
   localparam logic [1:0] SEL_NONE    = 2'd3;

   localparam int MST_DWIDTH_DEF = 32;
   localparam int SYS_DWIDTH_DEF = 8;

   typedef enum logic {IDLE, FILL} state_t;

endpackage

// File: rtl/mux_packer_char_select.sv
// Combinational 3:1 source mux; yields the selected character and strobe so
// the packer never sees which channel it came from.
module char_select
   import mux_packer_pkg::*;
#(
   parameter int SYS_DWIDTH = SYS_DWIDTH_DEF
) (
   input  logic [1:0]            select,
   input  logic [SYS_DWIDTH-1:0] data0_i,
   input  logic                  valid0_i,
   input  logic [SYS_DWIDTH-1:0] data1_i,
   input  logic                  valid1_i,
   input  logic [SYS_DWIDTH-1:0] data2_i,
   input  logic                  valid2_i,
   output logic [SYS_DWIDTH-1:0] ch_o,
   output logic                  vld_o
);

   always_comb begin
      ch_o  = '0;
      vld_o = 1'b0;
      unique case (select)
         SEL_CAESAR:  begin ch_o = data0_i; vld_o = valid0_i; end
         SEL_SCYTALE: begin ch_o = data1_i; vld_o = valid1_i; end
         SEL_ZIGZAG:  begin ch_o = data2_i; vld_o = valid2_i; end
         default:     begin ch_o = '0;      vld_o = 1'b0;     end
      endcase
   end

endmodule

// File: rtl/mux_packer.sv
// Packs characters from the selected decryptor MSB-first into master words.
// Define MUX_PACKER_FLUSH_EN to emit partial words after FLUSH_IDLE idle cycles.
module mux_packer
   import mux_packer_pkg::*;
#(
   parameter int MST_DWIDTH = MST_DWIDTH_DEF,
   parameter int SYS_DWIDTH = SYS_DWIDTH_DEF,
   parameter int FLUSH_IDLE = 4
) (
   input  logic                                        clk_sys,
   input  logic                                        rst,
   input  logic [1:0]                                  select,
   input  logic [SYS_DWIDTH-1:0]                       data0_i,
   input  logic                                        valid0_i,
   input  logic [SYS_DWIDTH-1:0]                       data1_i,
   input  logic                                        valid1_i,
   input  logic [SYS_DWIDTH-1:0]                       data2_i,
   input  logic                                        valid2_i,
   output logic [MST_DWIDTH-1:0]                       data_o,
   output logic                                        valid_o,
   output logic [$clog2(MST_DWIDTH/SYS_DWIDTH):0]      bytes_o,
   output logic                                        drop_o
);

   localparam int N  = MST_DWIDTH / SYS_DWIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = $clog2(N) + 1;

   logic [SYS_DWIDTH-1:0] ch;
   logic                  acc;

   char_select #(.SYS_DWIDTH(SYS_DWIDTH)) u_sel (
      .select   (select),
      .data0_i  (data0_i),
      .valid0_i (valid0_i),
      .data1_i  (data1_i),
      .valid1_i (valid1_i),
      .data2_i  (data2_i),
      .valid2_i (valid2_i),
      .ch_o     (ch),
      .vld_o    (acc)
   );

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, base_cnt;
   logic [MST_DWIDTH-1:0] word_q, word_d, filled;
   logic [1:0]            sel_q;
   logic [MST_DWIDTH-1:0] data_q, data_d;
   logic [BW-1:0]         bytes_q, bytes_d;
   logic                  valid_q, valid_d, drop_q, drop_d, discard;
`ifdef MUX_PACKER_FLUSH_EN
   localparam int IW = $clog2(FLUSH_IDLE + 1);
   logic [IW-1:0]         idle_q, idle_d;
`endif

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         sel_q   <= SEL_NONE;
         data_q  <= '0;
         bytes_q <= '0;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
`ifdef MUX_PACKER_FLUSH_EN
         idle_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         sel_q   <= select;
         data_q  <= data_d;
         bytes_q <= bytes_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
`ifdef MUX_PACKER_FLUSH_EN
         idle_q  <= idle_d;
`endif
      end
   end

   always_comb begin
      data_d  = data_q;
      bytes_d = bytes_q;
      valid_d = 1'b0;
      // A source switch mid-word throws the partial word away; a character
      // arriving in the same cycle then starts a fresh word at lane 0.
      discard  = (state_q == FILL) && (select != sel_q);
      drop_d   = discard;
      base_cnt = discard ? '0 : cnt_q;
      filled   = discard ? '0 : word_q;
      cnt_d    = base_cnt;
      word_d   = filled;
`ifdef MUX_PACKER_FLUSH_EN
      idle_d   = '0;
`endif
      if (acc) begin
         for (int k = 0; k < N; k++) begin
            if (base_cnt == CW'(k))
               filled[SYS_DWIDTH*(N-1-k) +: SYS_DWIDTH] = ch;
         end
         if (base_cnt == CW'(N-1)) begin
            data_d  = filled;
            bytes_d = BW'(N);
            valid_d = 1'b1;
            cnt_d   = '0;
            word_d  = '0;
         end else begin
            cnt_d   = base_cnt + 1'b1;
            word_d  = filled;
         end
      end
`ifdef MUX_PACKER_FLUSH_EN
      else if (base_cnt != '0) begin
         if (idle_q == IW'(FLUSH_IDLE - 1)) begin
            data_d  = word_q;
            bytes_d = BW'(cnt_q);
            valid_d = 1'b1;
            cnt_d   = '0;
            word_d  = '0;
         end else begin
            idle_d  = idle_q + 1'b1;
         end
      end
`endif
      state_d = (cnt_d == '0) ? IDLE : FILL;
   end

   assign data_o  = data_q;
   assign bytes_o = bytes_q;
   assign valid_o = valid_q;
   assign drop_o  = drop_q;

endmodule
